// File: rtl/dvr_router.sv
// dvr_router
// Sits between comm_fpga_fx2 and four application ports, splitting the
// 128-channel space into four 32-channel windows (port = chanAddr_in[6:5]).
//
// Host-to-FPGA writes go through a 2-entry FIFO. Each entry is tagged with
// the port and local channel that were selected when it was pushed, so a
// channel change while bytes are still buffered simply lets the old bytes
// drain to their original destination.
//
// FPGA-to-host reads are a combinational mux onto the selected port. They
// are held off while any write is still buffered, so a read can never
// overtake an earlier write.
//
// Ports:
//   clk_in           system clock (fx2Clk_in domain)
//   reset_in         synchronous, active-low reset
//   chanAddr_in      channel selected by comm_fpga_fx2
//   h2fData_in       host write data
//   h2fValid_in      host write byte offered
//   h2fReady_out     router can accept a write byte
//   f2hData_out      host read data
//   f2hValid_out     read byte available
//   f2hReady_in      comm_fpga_fx2 takes the read byte at this edge
//   appH2fChan_out   local channel of the FIFO head entry
//   appH2fData_out   data of the FIFO head entry (shared by all ports)
//   appH2fValid_out  one-hot: head entry offered to port p
//   appH2fReady_in   port p accepts the head entry
//   appF2hChan_out   chanAddr_in[4:0], passed through live
//   appF2hData_in    port p read data on bits [8p+7:8p]
//   appF2hValid_in   port p has a read byte
//   appF2hReady_out  port p read byte consumed at this edge

module dvr_router #(
  parameter int NUM_PORTS  = 4,
  parameter int LOCAL_BITS = 5
) (
  input  logic                    clk_in,
  input  logic                    reset_in,
  input  logic [6:0]              chanAddr_in,
  input  logic [7:0]              h2fData_in,
  input  logic                    h2fValid_in,
  output logic                    h2fReady_out,
  output logic [7:0]              f2hData_out,
  output logic                    f2hValid_out,
  input  logic                    f2hReady_in,
  output logic [LOCAL_BITS-1:0]   appH2fChan_out,
  output logic [7:0]              appH2fData_out,
  output logic [NUM_PORTS-1:0]    appH2fValid_out,
  input  logic [NUM_PORTS-1:0]    appH2fReady_in,
  output logic [LOCAL_BITS-1:0]   appF2hChan_out,
  input  logic [8*NUM_PORTS-1:0]  appF2hData_in,
  input  logic [NUM_PORTS-1:0]    appF2hValid_in,
  output logic [NUM_PORTS-1:0]    appF2hReady_out
);

  localparam int PORT_W = 7 - LOCAL_BITS;

  // Control state
  logic       r_en;
  logic [1:0] r_count;
  logic       r_head;
  logic       r_tail;

  // FIFO storage (data only, never reset)
  logic [PORT_W-1:0]     r_port [2];
  logic [LOCAL_BITS-1:0] r_chan [2];
  logic [7:0]            r_data [2];

  logic              w_nonempty;
  logic              w_ready;
  logic              w_push;
  logic              w_pop;
  logic              w_drained;
  logic [PORT_W-1:0] w_head_port;
  logic [PORT_W-1:0] w_rd_port;

  // Write side: ready comes only from registered state
  assign w_nonempty   = (r_count != 2'd0);
  assign w_ready      = r_en && (r_count != 2'd2);
  assign h2fReady_out = w_ready;
  assign w_push       = h2fValid_in && w_ready;

  // Only the head entry's own port can pop it
  assign w_head_port  = r_port[r_head];
  assign w_pop        = w_nonempty && appH2fReady_in[w_head_port];

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      r_en    <= 1'b0;
      r_count <= 2'd0;
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
    end else begin
      r_en <= 1'b1;
      if (w_push) begin
        r_tail <= ~r_tail;
      end
      if (w_pop) begin
        r_head <= ~r_head;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry captures its port/channel tag at push time
  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_port[r_tail] <= chanAddr_in[6:LOCAL_BITS];
      r_chan[r_tail] <= chanAddr_in[LOCAL_BITS-1:0];
      r_data[r_tail] <= h2fData_in;
    end
  end

  assign appH2fChan_out = r_chan[r_head];
  assign appH2fData_out = r_data[r_head];

  always_comb begin
    appH2fValid_out = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      appH2fValid_out[p] = w_nonempty && (w_head_port == p[PORT_W-1:0]);
    end
  end

  // Read side: live mux, gated until all buffered writes have left
  assign w_rd_port      = chanAddr_in[6:LOCAL_BITS];
  assign w_drained      = !w_nonempty && r_en;
  assign appF2hChan_out = chanAddr_in[LOCAL_BITS-1:0];
  assign f2hData_out    = appF2hData_in[{w_rd_port, 3'b000} +: 8];
  assign f2hValid_out   = w_drained && appF2hValid_in[w_rd_port];

  always_comb begin
    appF2hReady_out = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      appF2hReady_out[p] = w_drained && f2hReady_in &&
                           (w_rd_port == p[PORT_W-1:0]);
    end
  end

endmodule

// File: doc/dvr_router.md
Name: dvr_router

Overview:
- Sits between comm_fpga_fx2 and up to four application modules (swled and peers).
- Splits the 128-channel DVR space into four 32-channel windows, one per application port.
- Buffers host-to-FPGA writes in a 2-entry tagged FIFO, so downstream backpressure is decoupled from comm_fpga_fx2.
- Blocks FPGA-to-host reads until every earlier write has drained, which preserves write-then-read ordering.

Parameters:
- NUM_PORTS, 4, number of application ports. Must be 4: the port index is always chanAddr_in[6:5].
- LOCAL_BITS, 5, width of the per-port local channel address. Equals 7 − log2(NUM_PORTS).

Ports:
- clk_in  input  1  single system clock (fx2Clk_in domain)
- reset_in  input  1  synchronous, active-low reset
- chanAddr_in  input  7  channel selected by comm_fpga_fx2
- h2fData_in  input  8  host write data
- h2fValid_in  input  1  host write byte offered
- h2fReady_out  output  1  router can accept a write byte
- f2hData_out  output  8  host read data
- f2hValid_out  output  1  read byte available
- f2hReady_in  input  1  comm_fpga_fx2 takes the read byte at this edge
- appH2fChan_out  output  5  local channel of the FIFO head entry
- appH2fData_out  output  8  data of the FIFO head entry (shared by all ports)
- appH2fValid_out  output  4  one-hot: head entry offered to port p
- appH2fReady_in  input  4  port p accepts the head entry
- appF2hChan_out  output  5  chanAddr_in[4:0], passed through live
- appF2hData_in  input  32  port p read data on bits [8p+7:8p]
- appF2hValid_in  input  4  port p has a read byte
- appF2hReady_out  output  4  port p byte consumed at this edge

Behaviour:
- Reset (reset_in low at a rising edge):
  - FIFO count = 0; head and tail pointers = 0; en = 0.
  - h2fReady_out = 0; appH2fValid_out = 0; f2hValid_out = 0; appF2hReady_out = 0.
  - en sets on the first edge with reset_in high; h2fReady_out can rise one cycle after reset releases.
- Reset mid-operation: buffered entries are discarded and never presented. Acceptable, because comm_fpga_fx2 is reset alongside the router.
- FIFO entry = {port = chanAddr_in[6:5], chan = chanAddr_in[4:0], data = h2fData_in}, captured at push time.
- h2fReady_out = en AND (count < 2), decoded from registered state only.
- Push: h2fValid_in AND h2fReady_out at the edge.
- Head presentation: when count > 0, appH2fValid_out[head.port] = 1, all other bits 0; appH2fData_out and appH2fChan_out come from the head entry.
- Pop: count > 0 AND appH2fReady_in[head.port]. appH2fReady_in bits of non-head ports are ignored.
- Count transitions:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged (legal only at count 1, since h2fReady_out = 0 at count 2)
  - count 0: no pop is possible; a push sets the head
  - count 2: no push is possible
- Pointers are 1 bit each and wrap modulo 2.
- Latency: a byte accepted at edge N is visible on the app port in cycle N+1 (with an empty FIFO). A pop at edge N with count 2 exposes the next entry in cycle N+1.
- Channel changes while the FIFO is non-empty: entries keep their captured port and channel tag, so no flush occurs and bytes for the old channel drain in order.
- Read path is combinational with one gate:
  - Let p = chanAddr_in[6:5] and drained = (count == 0) AND en.
  - f2hData_out = appF2hData_in[8p+7:8p], always.
  - f2hValid_out = drained AND appF2hValid_in[p].
  - appF2hReady_out[p] = drained AND f2hReady_in; all other bits 0.
- While count > 0, reads stall (f2hValid_out = 0) and no app read byte is consumed.
- Unmapped channels do not exist: all 128 channels map to some port.

Test Plan:
- Reset: hold reset_in low 3 cycles with h2fValid_in = 1 → h2fReady_out = 0 and count stays 0; h2fReady_out = 1 in the second cycle after reset_in rises.
- Routing: write 0xA5 to chan 0x23 with all app ports ready → cycle N+1: appH2fValid_out = 4'b0010, appH2fChan_out = 5'h03, appH2fData_out = 0xA5; popped at edge N+1.
- Backpressure: appH2fReady_in = 0; write 0x11 and 0x22 to chan 0x45 → h2fReady_out = 0 after the second push. Release → 0x11 then 0x22 on port 2, one per cycle.
- Tag retention: write 0x33 to chan 0x05 (port 0 stalled), then write 0x44 to chan 0x65 → port 0 receives 0x33 before port 3 sees 0x44; appH2fValid_out is 0001, then 1000.
- Ordering gate: write 0x77 to chan 0x10 with port 0 stalled, then switch to read chan 0x10 with appF2hValid_in[0] = 1 and f2hReady_in = 1 → f2hValid_out = 0 and appF2hReady_out = 0 until port 0 pops; f2hValid_out = 1 in the cycle after the pop.
- Read mux: chan 0x7F, port 3 data 0xC3, valid, f2hReady_in = 1 → f2hData_out = 0xC3, appF2hReady_out = 4'b1000 for the whole stream.
